disaggregator: RTL and testbench

Width-splitting stage that unpacks one wide `FETCH_WIDTH*DATA_WIDTH` word from an upstream FIFO-style source into `FETCH_WIDTH` narrow `DATA_WIDTH` words. It emits the narrow words one per cycle to a downstream FIFO-style sink. It is the inverse of the existing aggregator: it sits between wide-word producers (tree and leaf result buffers) and the narrow async FIFO/IO path. Its handshake and lane ordering match the aggregator, so the two blocks form a lossless round trip.

---
 rtl/ann_io_pkg.sv | 19 +
 rtl/disaggregator_if.sv | 53 +++++
 rtl/disaggregator.sv | 75 +++++++
 tb/tb_disaggregator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ann_io_pkg.sv
// ann_io_pkg
//   Types and default sizes shared by the aggregator/disaggregator pair on
//   the ANN IO path. Both blocks take their default geometry from here, so
//   a round trip between them agrees on lane width and lane count.
//
//   disagg_state_t      : disaggregator FSM state (EMPTY, DRAIN)
//   DSIZE               : default narrow word width
//   FETCH_WIDTH_DEFAULT : default number of narrow words per wide word
package ann_io_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } disagg_state_t;

  localparam int DSIZE               = 11;
  localparam int FETCH_WIDTH_DEFAULT = 2;

endpackage

// File: rtl/disaggregator_if.sv
// disaggregator_if
//   Bundles the wide FIFO-style source side and the narrow FIFO-style sink
//   side of the disaggregator.
//
//   sender_data     : wide word offered by the source
//   sender_empty_n  : source holds a word
//   sender_deq      : pop the source this cycle
//   receiver_data   : current narrow word
//   receiver_full_n : sink can accept a word
//   receiver_enq    : push receiver_data this cycle
//   receiver_last   : final lane of a wide word (only with DISAGGREGATOR_LAST_EN)
//
//   Modports: slave  -> the disaggregator itself
//             master -> whatever drives/observes it (source + sink side)
//   Optional feature macro: DISAGGREGATOR_LAST_EN
interface disaggregator_if
  import ann_io_pkg::*;
#(
  parameter int DATA_WIDTH  = DSIZE,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEFAULT
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;
`ifdef DISAGGREGATOR_LAST_EN
  logic                              receiver_last;
`endif

`ifdef DISAGGREGATOR_LAST_EN
  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq, receiver_last
  );
  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq, receiver_last
  );
`else
  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );
  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );
`endif

endinterface

// File: rtl/disaggregator.sv
// disaggregator
//   Unpacks one FETCH_WIDTH*DATA_WIDTH word from a FIFO-style source into
//   FETCH_WIDTH narrow words, emitted one per cycle, lane 0 (low bits) first.
//   Inverse of the aggregator: same handshake, same lane order.
//
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     io  : disaggregator_if.slave (sender_* source side, receiver_* sink side)
//
//   Optional feature macro: DISAGGREGATOR_LAST_EN adds io.receiver_last,
//   high while the final lane of a wide word is presented.
module disaggregator
  import ann_io_pkg::*;
#(
  parameter int DATA_WIDTH  = DSIZE,
  parameter int FETCH_WIDTH = FETCH_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  disaggregator_if.slave  io
);

  localparam int            WIDE_W   = FETCH_WIDTH * DATA_WIDTH;
  localparam int            IDX_W    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FETCH_WIDTH - 1);

  disagg_state_t     state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [WIDE_W-1:0] shift_reg;

  logic at_last;
  logic enq;
  logic deq;

  assign at_last = (idx_reg == LAST_IDX);

  // Both handshakes are held off during reset so nothing moves in the reset
  // cycle even though the state register still shows the pre-reset value.
  assign enq = !rst && (state_reg == DRAIN) && io.receiver_full_n;
  assign deq = !rst && io.sender_empty_n &&
               ((state_reg == EMPTY) ||
                ((state_reg == DRAIN) && at_last && io.receiver_full_n));

  assign io.receiver_enq  = enq;
  assign io.sender_deq    = deq;
  assign io.receiver_data = shift_reg[DATA_WIDTH-1:0];

`ifdef DISAGGREGATOR_LAST_EN
  assign io.receiver_last = (state_reg == DRAIN) && at_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (deq) begin
      // A load on the last-lane edge replaces the drained word directly,
      // which is what keeps the output gap-free across word boundaries.
      state_reg <= DRAIN;
      idx_reg   <= '0;
      shift_reg <= io.sender_data;
    end else if (enq) begin
      if (at_last) begin
        state_reg <= EMPTY;
        idx_reg   <= '0;
      end else begin
        shift_reg <= shift_reg >> DATA_WIDTH;
        idx_reg   <= idx_reg + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_disaggregator.sv
// tb_disaggregator
//   Directed checks of the disaggregator with DATA_WIDTH=11, FETCH_WIDTH=2,
//   plus a randomly stalled stream compared against an in-order list of
//   expected narrow words. Inputs change 1 time unit after the rising edge;
//   outputs are sampled on the falling edge.
module tb_disaggregator;
  import ann_io_pkg::*;

  localparam int DW = 11;
  localparam int FW = 2;
  localparam int NWORDS = 200;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) io ();

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.sender_empty_n  = 1'b1;
    io.receiver_full_n = 1'b1;
    io.sender_data     = 22'h3FFFFF;
    step();
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b0) begin errors++; $display("FAIL reset_deq: got %b want 0", io.sender_deq); end
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL reset_enq: got %b want 0", io.receiver_enq); end
    checks++; if (io.receiver_data !== 11'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", io.receiver_data); end
    step();
    rst = 1'b0;
    io.sender_empty_n = 1'b0;
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b0) begin errors++; $display("FAIL idle_deq: got %b want 0", io.sender_deq); end
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL idle_enq: got %b want 0", io.receiver_enq); end
    step();
    $display("test_reset done");
  endtask

  task automatic test_single();
    io.sender_data = {11'd3, 11'd1}; io.sender_empty_n = 1'b1; io.receiver_full_n = 1'b1;
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b1) begin errors++; $display("FAIL single_deq_c0: got %b want 1", io.sender_deq); end
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL single_enq_c0: got %b want 0", io.receiver_enq); end
    step();
    io.sender_empty_n = 1'b0;
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd1) begin errors++; $display("FAIL single_c1: enq=%b data=%0d want enq=1 data=1", io.receiver_enq, io.receiver_data); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd3) begin errors++; $display("FAIL single_c2: enq=%b data=%0d want enq=1 data=3", io.receiver_enq, io.receiver_data); end
    checks++; if (io.sender_deq !== 1'b0) begin errors++; $display("FAIL single_deq_c2: got %b want 0", io.sender_deq); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL single_enq_c3: got %b want 0", io.receiver_enq); end
    $display("test_single done");
  endtask

  task automatic test_backpressure();
    step();
    io.sender_data = {11'd3, 11'd1}; io.sender_empty_n = 1'b1; io.receiver_full_n = 1'b1;
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b1) begin errors++; $display("FAIL bp_deq_c0: got %b want 1", io.sender_deq); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd1 || io.sender_deq !== 1'b0) begin errors++; $display("FAIL bp_c1: enq=%b data=%0d deq=%b want 1/1/0", io.receiver_enq, io.receiver_data, io.sender_deq); end
    for (int c = 2; c <= 4; c++) begin
      step();
      io.receiver_full_n = 1'b0;
      @(negedge clk);
      checks++; if (io.receiver_enq !== 1'b0 || io.receiver_data !== 11'd3 || io.sender_deq !== 1'b0) begin errors++; $display("FAIL bp_stall_c%0d: enq=%b data=%0d deq=%b want 0/3/0", c, io.receiver_enq, io.receiver_data, io.sender_deq); end
    end
    step();
    io.receiver_full_n = 1'b1; io.sender_empty_n = 1'b0;
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd3) begin errors++; $display("FAIL bp_c5: enq=%b data=%0d want enq=1 data=3", io.receiver_enq, io.receiver_data); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL bp_enq_c6: got %b want 0", io.receiver_enq); end
    $display("test_backpressure done");
  endtask

  task automatic test_back_to_back();
    step();
    io.sender_data = {11'd2, 11'd1}; io.sender_empty_n = 1'b1; io.receiver_full_n = 1'b1;
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b1) begin errors++; $display("FAIL b2b_deq_c0: got %b want 1", io.sender_deq); end
    step();
    io.sender_data = {11'd4, 11'd3};
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd1 || io.sender_deq !== 1'b0) begin errors++; $display("FAIL b2b_c1: enq=%b data=%0d deq=%b want 1/1/0", io.receiver_enq, io.receiver_data, io.sender_deq); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd2 || io.sender_deq !== 1'b1) begin errors++; $display("FAIL b2b_c2: enq=%b data=%0d deq=%b want 1/2/1", io.receiver_enq, io.receiver_data, io.sender_deq); end
    step();
    io.sender_empty_n = 1'b0;
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd3) begin errors++; $display("FAIL b2b_c3: enq=%b data=%0d want enq=1 data=3", io.receiver_enq, io.receiver_data); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd4) begin errors++; $display("FAIL b2b_c4: enq=%b data=%0d want enq=1 data=4", io.receiver_enq, io.receiver_data); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL b2b_enq_c5: got %b want 0", io.receiver_enq); end
    $display("test_back_to_back done");
  endtask

  task automatic test_starved();
    io.sender_empty_n = 1'b0; io.receiver_full_n = 1'b1; io.sender_data = {11'd7, 11'd9};
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      checks++; if (io.sender_deq !== 1'b0 || io.receiver_enq !== 1'b0) begin errors++; $display("FAIL starved_c%0d: deq=%b enq=%b want 0/0", c, io.sender_deq, io.receiver_enq); end
    end
    $display("test_starved done");
  endtask

  task automatic test_reset_midword();
    step();
    io.sender_data = {11'd3, 11'd1}; io.sender_empty_n = 1'b1; io.receiver_full_n = 1'b1;
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b1) begin errors++; $display("FAIL rmw_deq_c0: got %b want 1", io.sender_deq); end
    step();
    io.sender_empty_n = 1'b0;
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd1) begin errors++; $display("FAIL rmw_c1: enq=%b data=%0d want enq=1 data=1", io.receiver_enq, io.receiver_data); end
    step();
    rst = 1'b1; io.sender_data = {11'd6, 11'd5}; io.sender_empty_n = 1'b1;
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b0 || io.sender_deq !== 1'b0) begin errors++; $display("FAIL rmw_rst_cycle: enq=%b deq=%b want 0/0", io.receiver_enq, io.sender_deq); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (io.sender_deq !== 1'b1 || io.receiver_enq !== 1'b0) begin errors++; $display("FAIL rmw_c3: deq=%b enq=%b want 1/0", io.sender_deq, io.receiver_enq); end
    step();
    io.sender_empty_n = 1'b0;
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd5) begin errors++; $display("FAIL rmw_c4: enq=%b data=%0d want enq=1 data=5", io.receiver_enq, io.receiver_data); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b1 || io.receiver_data !== 11'd6) begin errors++; $display("FAIL rmw_c5: enq=%b data=%0d want enq=1 data=6", io.receiver_enq, io.receiver_data); end
    step();
    @(negedge clk);
    checks++; if (io.receiver_enq !== 1'b0) begin errors++; $display("FAIL rmw_enq_c6: got %b want 0", io.receiver_enq); end
    $display("test_reset_midword done");
  endtask

  // Randomly stalled source and sink; the bench's own list of lanes (low
  // lane first) is the reference order.
  task automatic test_stream();
    logic [FW*DW-1:0] words [NWORDS];
    logic [DW-1:0]    expect_q [$];
    int               wi = 0;
    int               nout = 0;
    int               budget = 0;
    for (int i = 0; i < NWORDS; i++) begin
      words[i] = {11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047))};
      expect_q.push_back(words[i][DW-1:0]);
      expect_q.push_back(words[i][2*DW-1:DW]);
    end
    step();
    while (nout < 2 * NWORDS && budget < 5000) begin
      io.sender_empty_n  = (wi < NWORDS) && ($urandom_range(0, 3) != 0);
      io.sender_data     = (wi < NWORDS) ? words[wi] : 22'($urandom);
      io.receiver_full_n = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (io.receiver_enq === 1'b1) begin
        checks++;
        if (io.receiver_data !== expect_q[nout]) begin
          errors++; $display("FAIL stream_data[%0d]: got %0d want %0d", nout, io.receiver_data, expect_q[nout]);
        end
`ifdef DISAGGREGATOR_LAST_EN
        checks++;
        if (io.receiver_last !== ((nout % 2) == 1)) begin
          errors++; $display("FAIL stream_last[%0d]: got %b want %b", nout, io.receiver_last, (nout % 2) == 1);
        end
`endif
        nout++;
      end
      if (io.sender_deq === 1'b1) wi++;
      budget++;
      step();
    end
    checks++;
    if (nout != 2 * NWORDS) begin errors++; $display("FAIL stream_count: got %0d want %0d", nout, 2 * NWORDS); end
    io.sender_empty_n = 1'b0;
    $display("test_stream done: %0d words in, %0d lanes out", wi, nout);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_starved();
    test_reset_midword();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
